// File: rtl/lane_reorder_if.sv
// Lane reorder bus: deskewed tagged lanes in, logically ordered blocks out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the stage is a pure valid-qualified pipeline.
interface lane_reorder_if #(
  parameter int N_LANES      = 20,
  parameter int NB_DATA      = 66,
  parameter int NB_FIFO_DATA = 67
);
  logic                              i_enable;
  logic                              i_valid;
  logic                              i_deskew_done;
  logic [NB_FIFO_DATA*N_LANES-1:0]   i_data;
  logic [NB_DATA*N_LANES-1:0]        o_data;
  logic                              o_valid;
  logic                              o_am_flag;
  logic                              o_reorder_done;
  logic                              o_lane_id_error;

  // Upstream side: drives the tagged lanes, observes the reordered result.
  modport master (
    output i_enable, i_valid, i_deskew_done, i_data,
    input  o_data, o_valid, o_am_flag, o_reorder_done, o_lane_id_error
  );

  // Reorder stage side.
  modport slave (
    input  i_enable, i_valid, i_deskew_done, i_data,
    output o_data, o_valid, o_am_flag, o_reorder_done, o_lane_id_error
  );
endinterface

// File: rtl/lane_reorder.sv
// Decodes alignment markers into logical lane IDs, confirms the mapping, reorders blocks.
// Latency: one cycle from input to o_data/o_valid/o_am_flag.
// Backpressure: none; i_valid=0 or i_enable=0 freezes all state.
module lane_reorder #(
  parameter int N_LANES          = 20,
  parameter int NB_DATA          = 66,
  parameter int NB_FIFO_DATA     = 67,
  parameter int NB_ID            = $clog2(N_LANES),
  parameter int N_CONFIRM        = 2,
  parameter int MAX_MISMATCH     = 3,
  parameter int NB_DATA_BUS      = NB_DATA*N_LANES,
  parameter int NB_FIFO_DATA_BUS = NB_FIFO_DATA*N_LANES
) (
  input  logic          i_clock,
  input  logic          i_reset,
  lane_reorder_if.slave bus
);

  localparam int CW_CONF = $clog2(N_CONFIRM+1);
  localparam int CW_MIS  = $clog2(MAX_MISMATCH+1);
  localparam logic [CW_CONF-1:0] CONF_TOP = CW_CONF'(N_CONFIRM);
  localparam logic [CW_MIS-1:0]  MIS_TOP  = CW_MIS'(MAX_MISMATCH);

  typedef enum logic [1:0] {ST_WAIT, ST_CAPTURE, ST_CONFIRM, ST_LOCKED} state_t;

  // 100GBASE-R alignment marker {M0,M1,M2} per logical lane.
  function automatic logic [23:0] am_code(input int k);
    case (k)
      0:  am_code = 24'hC16821;  1:  am_code = 24'h9D718E;
      2:  am_code = 24'h594BE8;  3:  am_code = 24'h4D957B;
      4:  am_code = 24'hF50709;  5:  am_code = 24'hDD14C2;
      6:  am_code = 24'h9A4A26;  7:  am_code = 24'h7B4566;
      8:  am_code = 24'hA02476;  9:  am_code = 24'h68C9FB;
      10: am_code = 24'hFD6C99;  11: am_code = 24'hB99155;
      12: am_code = 24'h5CB9B2;  13: am_code = 24'h1AF8BD;
      14: am_code = 24'h83C7CA;  15: am_code = 24'h3536CD;
      16: am_code = 24'hC4314C;  17: am_code = 24'hADD6B7;
      18: am_code = 24'h5F662A;  19: am_code = 24'hC0F0E5;
      default: am_code = 24'h000000;
    endcase
  endfunction

  state_t                    state_q, state_nxt;
  logic [NB_ID-1:0]          map_q [N_LANES];
  logic [CW_CONF-1:0]        conf_q, conf_nxt, conf_inc;
  logic [CW_MIS-1:0]         mis_q, mis_nxt, mis_inc;
  logic                      map_wr, map_clr;

  logic [NB_FIFO_DATA-1:0]   lane_c [N_LANES];
  logic [NB_ID-1:0]          lane_id_c [N_LANES];
  logic [N_LANES-1:0]        seen_c;
  logic                      all_ok_c, uniq_c, match_c, all_tag_c, any_tag_c;
  logic                      adv, am_cyc, part_cyc, cap_ok, good;
  logic                      err_c, done_c;
  logic [NB_DATA_BUS-1:0]    data_c;

  logic [NB_DATA_BUS-1:0]    o_data_q;
  logic                      o_valid_q, o_am_q, o_done_q, o_err_q;

  // Split the bus into physical lanes and decode each lane's marker.
  always_comb begin
    seen_c    = '0;
    all_ok_c  = 1'b1;
    uniq_c    = 1'b1;
    match_c   = 1'b1;
    all_tag_c = 1'b1;
    any_tag_c = 1'b0;
    for (int p = 0; p < N_LANES; p++) begin
      lane_c[p]    = bus.i_data[NB_FIFO_DATA_BUS-1-p*NB_FIFO_DATA -: NB_FIFO_DATA];
      lane_id_c[p] = '0;
      all_tag_c    = all_tag_c & lane_c[p][NB_FIFO_DATA-1];
      any_tag_c    = any_tag_c | lane_c[p][NB_FIFO_DATA-1];
      if (lane_c[p][NB_DATA-1 -: 2] == 2'b01) begin
        for (int k = 0; k < N_LANES; k++) begin
          if (lane_c[p][NB_DATA-3 -: 24] == am_code(k)) lane_id_c[p] = NB_ID'(k);
        end
      end
      if ((lane_c[p][NB_DATA-1 -: 2] != 2'b01) ||
          (lane_c[p][NB_DATA-3 -: 24] != am_code(int'(lane_id_c[p])))) begin
        all_ok_c = 1'b0;
      end else begin
        if (seen_c[lane_id_c[p]]) uniq_c = 1'b0;
        seen_c[lane_id_c[p]] = 1'b1;
        if (map_q[lane_id_c[p]] != NB_ID'(p)) match_c = 1'b0;
      end
    end
  end

  assign adv      = bus.i_enable & bus.i_valid;
  assign am_cyc   = adv & bus.i_deskew_done & all_tag_c;
  assign part_cyc = adv & bus.i_deskew_done & any_tag_c & ~all_tag_c;
  assign cap_ok   = all_ok_c & uniq_c;
  assign good     = cap_ok & match_c;
  assign conf_inc = (conf_q == CONF_TOP) ? conf_q : conf_q + 1'b1;
  assign mis_inc  = (mis_q == MIS_TOP) ? mis_q : mis_q + 1'b1;

  // Route logical lane k from physical lane map[k], tag stripped.
  always_comb begin
    data_c = '0;
    for (int k = 0; k < N_LANES; k++) begin
      data_c[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA] = lane_c[map_q[k]][NB_DATA-1:0];
    end
  end

  // State, counter and map registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_WAIT;
      conf_q  <= '0;
      mis_q   <= '0;
      for (int k = 0; k < N_LANES; k++) map_q[k] <= NB_ID'(k);
    end else begin
      state_q <= state_nxt;
      conf_q  <= conf_nxt;
      mis_q   <= mis_nxt;
      if (map_clr) begin
        for (int k = 0; k < N_LANES; k++) map_q[k] <= NB_ID'(k);
      end else if (map_wr) begin
        for (int p = 0; p < N_LANES; p++) map_q[lane_id_c[p]] <= NB_ID'(p);
      end
    end
  end

  // Next state: deskew loss first, then per-state marker handling.
  always_comb begin
    state_nxt = state_q;
    conf_nxt  = conf_q;
    mis_nxt   = mis_q;
    map_wr    = 1'b0;
    map_clr   = 1'b0;
    if (adv) begin
      if (!bus.i_deskew_done) begin
        state_nxt = ST_WAIT;
        conf_nxt  = '0;
        mis_nxt   = '0;
        map_clr   = 1'b1;
      end else begin
        case (state_q)
          ST_WAIT: state_nxt = ST_CAPTURE;
          ST_CAPTURE: begin
            if (am_cyc && cap_ok) begin
              map_wr    = 1'b1;
              conf_nxt  = '0;
              mis_nxt   = '0;
              state_nxt = ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (am_cyc && good) begin
              conf_nxt = conf_inc;
              if (conf_inc == CONF_TOP) state_nxt = ST_LOCKED;
            end else if (am_cyc || part_cyc) begin
              state_nxt = ST_CAPTURE;
            end
          end
          ST_LOCKED: begin
            if (am_cyc && good) begin
              mis_nxt = '0;
            end else if (am_cyc || part_cyc) begin
              mis_nxt = mis_inc;
              if (mis_inc == MIS_TOP) state_nxt = ST_CAPTURE;
            end
          end
          default: state_nxt = ST_WAIT;
        endcase
      end
    end
  end

  // Status outputs: error on any bad marker cycle, done while locked.
  always_comb begin
    err_c = 1'b0;
    if (adv && bus.i_deskew_done) begin
      case (state_q)
        ST_CAPTURE:           err_c = (am_cyc && !cap_ok) || part_cyc;
        ST_CONFIRM, ST_LOCKED: err_c = (am_cyc && !good) || part_cyc;
        default:              err_c = 1'b0;
      endcase
    end
    done_c = (state_nxt == ST_LOCKED);
  end

  // Output register; data holds across invalid cycles.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_am_q    <= 1'b0;
      o_done_q  <= 1'b0;
      o_err_q   <= 1'b0;
    end else if (bus.i_enable) begin
      o_valid_q <= bus.i_valid;
      o_am_q    <= am_cyc;
      o_done_q  <= done_c;
      o_err_q   <= err_c;
      if (bus.i_valid) o_data_q <= data_c;
    end
  end

  assign bus.o_data          = o_data_q;
  assign bus.o_valid         = o_valid_q;
  assign bus.o_am_flag       = o_am_q;
  assign bus.o_reorder_done  = o_done_q;
  assign bus.o_lane_id_error = o_err_q;

endmodule

// File: tb/tb_lane_reorder.sv
// Directed scenarios with random block payloads, checked against a lane-ID level model.
// Latency: model predicts outputs one clock after each driven cycle.
// Backpressure: stimulus toggles i_valid/i_enable randomly in later scenarios.
module tb_lane_reorder;
  localparam int NL = 20, NBD = 66, NBF = 67;
  localparam int NCONF = 2, NMIS = 3;
  localparam int PH_WAIT = 0, PH_CAPTURE = 1, PH_CONFIRM = 2, PH_LOCKED = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lane_reorder_if #(.N_LANES(NL), .NB_DATA(NBD), .NB_FIFO_DATA(NBF)) bus ();

  lane_reorder #(
    .N_LANES(NL), .NB_DATA(NBD), .NB_FIFO_DATA(NBF),
    .N_CONFIRM(NCONF), .MAX_MISMATCH(NMIS)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string step = "reset";

  logic [23:0]    am_tab [NL];
  logic [NBD-1:0] blk [NL];
  logic           tag [NL];
  int             id_of [NL];
  int             ids_cfg [NL];
  int             corrupt_lane = -1;
  bit             rand_valid = 0;
  logic           cur_en, cur_vld, cur_dsk;

  int               m_phase, m_conf, m_mis;
  int               m_map [NL];
  logic [NBD*NL-1:0] e_data;
  logic             e_valid, e_am, e_err, e_done;

  task automatic chk1(input string tg, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%b expected=%b", step, tg, obs, exp);
    end
  endtask

  task automatic chk66(input string tg, input logic [NBD-1:0] obs, input logic [NBD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%h expected=%h", step, tg, obs, exp);
    end
  endtask

  task automatic chk_data();
    int bad;
    logic [NBD-1:0] ob, ex;
    bad = 0;
    for (int k = NL-1; k >= 0; k--)
      if (bus.o_data[NBD*NL-1-k*NBD -: NBD] !== e_data[NBD*NL-1-k*NBD -: NBD]) bad = k;
    ob = bus.o_data[NBD*NL-1-bad*NBD -: NBD];
    ex = e_data[NBD*NL-1-bad*NBD -: NBD];
    checks++;
    assert (bus.o_data === e_data) else begin
      failures++;
      $error("FAIL %s/o_data lane=%0d observed=%h expected=%h", step, bad, ob, ex);
    end
  endtask

  task automatic check_all();
    chk1("o_valid", bus.o_valid, e_valid);
    chk1("o_am_flag", bus.o_am_flag, e_am);
    chk1("o_lane_id_error", bus.o_lane_id_error, e_err);
    chk1("o_reorder_done", bus.o_reorder_done, e_done);
    chk_data();
  endtask

  task automatic model_reset();
    m_phase = PH_WAIT; m_conf = 0; m_mis = 0;
    for (int k = 0; k < NL; k++) m_map[k] = k;
    e_data = '0; e_valid = 0; e_am = 0; e_err = 0; e_done = 0;
  endtask

  // Lane-ID level reference: map[k] = physical lane carrying logical lane k.
  task automatic model_step();
    int  cnt [NL];
    bit  all_tag, any_tag, all_ok, uniq, match, am, part, good;
    if (!cur_en) return;
    all_tag = 1; any_tag = 0; all_ok = 1; uniq = 1; match = 1;
    for (int k = 0; k < NL; k++) cnt[k] = 0;
    for (int p = 0; p < NL; p++) begin
      all_tag &= tag[p];
      any_tag |= tag[p];
      if (id_of[p] < 0) all_ok = 0;
      else begin
        cnt[id_of[p]]++;
        if (cnt[id_of[p]] > 1) uniq = 0;
        if (m_map[id_of[p]] != p) match = 0;
      end
    end
    am   = cur_vld && cur_dsk && all_tag;
    part = cur_vld && cur_dsk && any_tag && !all_tag;
    good = all_ok && uniq && match;
    e_valid = cur_vld; e_am = am; e_err = 0;
    if (!cur_vld) return;
    for (int k = 0; k < NL; k++) e_data[NBD*NL-1-k*NBD -: NBD] = blk[m_map[k]];
    if (!cur_dsk) begin
      m_phase = PH_WAIT; m_conf = 0; m_mis = 0; e_done = 0;
      for (int k = 0; k < NL; k++) m_map[k] = k;
      return;
    end
    case (m_phase)
      PH_WAIT: m_phase = PH_CAPTURE;
      PH_CAPTURE:
        if (am && all_ok && uniq) begin
          for (int p = 0; p < NL; p++) m_map[id_of[p]] = p;
          m_conf = 0; m_mis = 0; m_phase = PH_CONFIRM;
        end else if (am || part) e_err = 1;
      PH_CONFIRM:
        if (am && good) begin
          m_conf++;
          if (m_conf == NCONF) m_phase = PH_LOCKED;
        end else if (am || part) begin
          e_err = 1; m_phase = PH_CAPTURE;
        end
      default:
        if (am && good) m_mis = 0;
        else if (am || part) begin
          e_err = 1; m_mis++;
          if (m_mis == NMIS) m_phase = PH_CAPTURE;
        end
    endcase
    e_done = (m_phase == PH_LOCKED);
  endtask

  task automatic drive(input logic en, input logic vld, input logic dsk);
    logic [NBF*NL-1:0] v;
    for (int p = 0; p < NL; p++) v[NBF*NL-1-p*NBF -: NBF] = {tag[p], blk[p]};
    cur_en = en; cur_vld = vld; cur_dsk = dsk;
    bus.i_enable = en; bus.i_valid = vld; bus.i_deskew_done = dsk; bus.i_data = v;
  endtask

  task automatic make_data();
    logic [95:0] r;
    for (int p = 0; p < NL; p++) begin
      r = {$urandom(), $urandom(), $urandom()};
      blk[p] = r[NBD-1:0]; tag[p] = 1'b0; id_of[p] = -1;
    end
  endtask

  task automatic make_partial();
    make_data();
    for (int p = 0; p < NL; p++) tag[p] = 1'($urandom_range(0, 1));
    tag[0] = 1'b1; tag[NL-1] = 1'b0;
  endtask

  task automatic make_am();
    logic [95:0] r;
    logic [23:0] code;
    for (int p = 0; p < NL; p++) begin
      r = {$urandom(), $urandom(), $urandom()};
      code = am_tab[ids_cfg[p]];
      id_of[p] = ids_cfg[p];
      if (p == corrupt_lane) begin
        code[15:8] = code[15:8] ^ 8'hFF;
        id_of[p] = -1;
      end
      blk[p] = {2'b01, code, r[39:0]}; tag[p] = 1'b1;
    end
  endtask

  task automatic cycle(input logic en, input logic vld, input logic dsk);
    drive(en, vld, dsk);
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic period(input int n_data);
    logic v;
    for (int c = 0; c < n_data; c++) begin
      make_data();
      v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(1'b1, v, 1'b1);
    end
    make_am();
    cycle(1'b1, 1'b1, 1'b1);
  endtask

  task automatic lose_deskew();
    make_data();
    cycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic set_ids(input bit reversed);
    for (int p = 0; p < NL; p++) ids_cfg[p] = reversed ? NL-1-p : p;
  endtask

  initial begin
    logic [NBD-1:0] saved;
    am_tab = '{24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
               24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
               24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
               24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};
    set_ids(0);
    make_data();
    drive(1'b0, 1'b0, 1'b0);
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    step = "identity";
    period(15); period(15);
    chk1("done_after_am2", bus.o_reorder_done, 1'b0);
    period(15);
    chk1("done_after_am3", bus.o_reorder_done, 1'b1);
    period(15); period(15);

    step = "reversed";
    rand_valid = 1;
    lose_deskew();
    set_ids(1);
    period(15); period(15); period(15);
    chk1("rev_locked", bus.o_reorder_done, 1'b1);
    make_data();
    saved = blk[NL-1];
    cycle(1'b1, 1'b1, 1'b1);
    chk66("rev_logical0", bus.o_data[NBD*NL-1 -: NBD], saved);

    step = "duplicate";
    lose_deskew();
    set_ids(0);
    ids_cfg[3] = 5; ids_cfg[7] = 5;
    for (int i = 0; i < 3; i++) begin
      period(15);
      chk1("dup_err", bus.o_lane_id_error, 1'b1);
    end
    chk1("dup_not_locked", bus.o_reorder_done, 1'b0);

    step = "mismatch";
    lose_deskew();
    set_ids(0);
    period(15); period(15); period(15);
    chk1("mm_locked", bus.o_reorder_done, 1'b1);
    corrupt_lane = 4;
    period(15); chk1("mm_err1", bus.o_lane_id_error, 1'b1);
    period(15); chk1("mm_err2", bus.o_lane_id_error, 1'b1);
    chk1("mm_held", bus.o_reorder_done, 1'b1);
    corrupt_lane = -1;
    period(15);
    corrupt_lane = 4;
    period(15); period(15);
    chk1("mm_held2", bus.o_reorder_done, 1'b1);
    period(15);
    chk1("mm_err3", bus.o_lane_id_error, 1'b1);
    chk1("mm_dropped", bus.o_reorder_done, 1'b0);
    corrupt_lane = -1;
    period(15); period(15); period(15);
    chk1("mm_relocked", bus.o_reorder_done, 1'b1);

    step = "deskew_loss";
    lose_deskew();
    set_ids(1);
    period(15); period(15); period(15);
    for (int c = 0; c < 7; c++) begin
      make_data();
      cycle(1'b1, 1'b1, 1'b1);
    end
    lose_deskew();
    chk1("dl_done", bus.o_reorder_done, 1'b0);
    make_data();
    saved = blk[0];
    cycle(1'b1, 1'b1, 1'b1);
    chk66("dl_identity", bus.o_data[NBD*NL-1 -: NBD], saved);

    step = "random";
    set_ids(0);
    period(15); period(15); period(15);
    make_partial();
    cycle(1'b1, 1'b1, 1'b1);
    chk1("partial_err", bus.o_lane_id_error, 1'b1);
    period(15);
    for (int c = 0; c < 24; c++) begin
      make_data();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    period(15);

    step = "async_reset";
    chk1("ar_locked", bus.o_reorder_done, 1'b1);
    make_data();
    drive(1'b1, 1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    period(15); period(15); period(15);
    chk1("ar_relocked", bus.o_reorder_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
